truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/lab1_pkg.sv | 14 +
 rtl/hold_counter.sv | 34 +++
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Shared types and constants for the truth-table sweeper.
package lab1_pkg;

  localparam int NUM_VECTORS         = 16;
  localparam int VEC_W               = 4;
  localparam int HOLD_CYCLES_DEFAULT = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/hold_counter.sv
// Up-counter that paces how long each input vector is held.
// It counts 0..HOLD_CYCLES-1 while enabled. It wraps to 0 after the last count.
// tc marks the last cycle of a hold.
module hold_counter #(
  parameter int unsigned HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] count;

  // Terminal count is a plain compare so the wrap can never overshoot.
  always_comb tc = (count == LAST);

  // Count register: clear wins over enable, and the counter wraps on terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable) begin
      if (tc)
        count <= '0;
      else
        count <= count + W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors into a 4-input combinational function.
// It samples F on the last cycle of each hold.
// At the end it reports the captured table and whether it matches the golden table.
//
// state | meaning
// IDLE  | waiting for start; results from the previous sweep are held
// APPLY | vector on abcd, hold counter running, capture F at terminal count
// DONE  | one-cycle completion pulse; valid/pass already registered
module truth_table_sweeper
  import lab1_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   f_in,
  input  logic [NUM_VECTORS-1:0] expected,
  output logic [VEC_W-1:0]       abcd,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic                   valid,
  output logic                   pass
);

  state_t state, state_next;

  logic                   hold_tc;
  logic                   cnt_clear;
  logic                   cnt_en;
  logic                   sweep_init;
  logic                   capture;
  logic                   last_vec;
  logic [NUM_VECTORS-1:0] table_next;

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .enable(cnt_en),
    .tc    (hold_tc)
  );

  // State register; reset dominates any start request.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    sweep_init = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = APPLY;
          cnt_clear  = 1'b1;
          sweep_init = 1'b1;
        end
      end
      APPLY: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (hold_tc) begin
          capture = 1'b1;
          if (last_vec)
            state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb last_vec = (abcd == VEC_W'(NUM_VECTORS - 1));

  // Table including the bit being captured this cycle.
  // This lets pass see the complete result on the final capture.
  always_comb begin
    table_next       = truth_table;
    table_next[abcd] = f_in;
  end

  // Datapath: vector stepping, capture, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      abcd        <= '0;
      truth_table <= '0;
      valid       <= 1'b0;
      pass        <= 1'b0;
    end else if (sweep_init) begin
      abcd        <= '0;
      truth_table <= '0;
      valid       <= 1'b0;
      pass        <= 1'b0;
    end else if (capture) begin
      truth_table <= table_next;
      if (last_vec) begin
        abcd  <= '0;
        valid <= 1'b1;
        pass  <= (table_next == expected);
      end else begin
        abcd <= abcd + VEC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper.
// One instance uses a hold of 4 and drives F=A&B|C&D.
// A second instance uses a hold of 50 and drives F=1.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0;
  logic        start50 = 1'b0;
  logic [15:0] expected4 = 16'hF888;
  logic [15:0] expected50 = 16'hFFFF;

  logic [3:0]  abcd4, abcd50;
  logic        busy4, busy50, done4, done50, valid4, valid50, pass4, pass50;
  logic [15:0] tt4, tt50;
  logic        f4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign f4 = (abcd4[3] & abcd4[2]) | (abcd4[1] & abcd4[0]);

  truth_table_sweeper #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f4), .expected(expected4),
    .abcd(abcd4), .busy(busy4), .done(done4), .truth_table(tt4),
    .valid(valid4), .pass(pass4)
  );

  truth_table_sweeper #(.HOLD_CYCLES(50)) dut50 (
    .clk(clk), .rst(rst), .start(start50), .f_in(1'b1), .expected(expected50),
    .abcd(abcd50), .busy(busy50), .done(done50), .truth_table(tt50),
    .valid(valid50), .pass(pass50)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_val);
    end
  endtask

  // Pulse start on dut4 and follow the sweep for 80 cycles.
  // The caller arrives at a negedge. Cycle n counts from the edge that sampled start.
  // Nonzero restart_a/b re-assert start during those cycles.
  // A nonzero rst_at raises rst during that cycle.
  task automatic sweep4(input int restart_a, input int restart_b, input int rst_at,
                        output int done_at, output int done_cnt);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    done_at  = 0;
    done_cnt = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (rst_at == 0 && n <= 61 && ((n - 1) % 4) == 0)
        chk($sformatf("abcd_step_c%0d", n), 32'(abcd4), 32'((n - 1) / 4));
      if (n == 1)  chk("busy_first", 32'(busy4), 32'd1);
      if (rst_at == 0 && n == 64) chk("busy_last", 32'(busy4), 32'd1);
      if (rst_at == 0 && n == 65) chk("busy_in_done", 32'(busy4), 32'd0);
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("rst_mid_abcd",  32'(abcd4),  32'd0);
        chk("rst_mid_busy",  32'(busy4),  32'd0);
        chk("rst_mid_valid", 32'(valid4), 32'd0);
        chk("rst_mid_tt",    32'(tt4),    32'd0);
      end
      if (done4) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      start4 = (n == restart_a || n == restart_b);
      rst    = (rst_at != 0 && n == rst_at);
    end
    start4 = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    int done_at, done_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_abcd",  32'(abcd4),  32'd0);
    chk("rst_busy",  32'(busy4),  32'd0);
    chk("rst_done",  32'(done4),  32'd0);
    chk("rst_tt",    32'(tt4),    32'd0);
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_pass",  32'(pass4),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Matching golden table
    sweep4(0, 0, 0, done_at, done_cnt);
    chk("match_done_at",  32'(done_at),  32'd65);
    chk("match_done_cnt", 32'(done_cnt), 32'd1);
    chk("match_tt",       32'(tt4),      32'hF888);
    chk("match_valid",    32'(valid4),   32'd1);
    chk("match_pass",     32'(pass4),    32'd1);
    chk("idle_abcd",      32'(abcd4),    32'd0);

    // Mismatching golden table
    expected4 = 16'hF889;
    sweep4(0, 0, 0, done_at, done_cnt);
    chk("mism_done_at", 32'(done_at), 32'd65);
    chk("mism_tt",      32'(tt4),     32'hF888);
    chk("mism_valid",   32'(valid4),  32'd1);
    chk("mism_pass",    32'(pass4),   32'd0);
    repeat (5) @(negedge clk);
    chk("hold_valid", 32'(valid4), 32'd1);
    chk("hold_tt",    32'(tt4),    32'hF888);

    // Start re-asserted during the sweep is ignored
    expected4 = 16'hF888;
    sweep4(10, 64, 0, done_at, done_cnt);
    chk("restart_done_at",  32'(done_at),  32'd65);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);
    chk("restart_busy_end", 32'(busy4),    32'd0);
    chk("restart_pass",     32'(pass4),    32'd1);

    // Reset mid-sweep
    sweep4(0, 0, 30, done_at, done_cnt);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_idle",    32'(busy4),    32'd0);

    // Reset and start together
    rst = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy4), 32'd0);
    chk("rst_start_abcd", 32'(abcd4), 32'd0);
    @(negedge clk);
    chk("rst_start_busy2", 32'(busy4), 32'd0);

    // Long hold, constant F
    start50 = 1'b1;
    @(posedge clk); #1;
    start50 = 1'b0;
    done_at = 0;
    for (int n = 1; n <= 820; n++) begin
      @(negedge clk);
      if (n == 51) chk("h50_abcd_1", 32'(abcd50), 32'd1);
      if (done50 && done_at == 0) done_at = n;
    end
    chk("h50_done_at", 32'(done_at), 32'd801);
    chk("h50_tt",      32'(tt50),    32'hFFFF);
    chk("h50_valid",   32'(valid50), 32'd1);
    chk("h50_pass",    32'(pass50),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
